// File: rtl/elevator_call_scheduler.sv
// SCAN-policy elevator call scheduler: latches floor calls, issues one-floor step
// commands over valid/ready, sequences the door dwell and flags a stalled car.
module elevator_call_scheduler #(
    parameter int NUM_FLOORS     = 4,
    parameter int FLOOR_W        = 2,
    parameter int DOOR_CYCLES    = 8,
    parameter int TRAVEL_TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NUM_FLOORS-1:0] call_req,
    input  logic [FLOOR_W-1:0]    car_floor,
    output logic                  cmd_valid,
    output logic                  cmd_dir,
    input  logic                  cmd_ready,
    input  logic                  step_done,
    output logic                  door_open,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  dir_up,
    output logic                  busy,
    output logic                  fault
);

    typedef enum logic [1:0] {IDLE, DISPATCH, TRAVEL, DOOR} state_t;

    localparam int DCNT_W = $clog2(DOOR_CYCLES + 1);
    localparam int TCNT_W = $clog2(TRAVEL_TIMEOUT + 1);

    state_t                state, next_state;
    logic                  next_dir;
    logic                  set_fault;
    logic                  door_reload;
    logic                  enter_door;
    logic [DCNT_W-1:0]     door_cnt;
    logic [TCNT_W-1:0]     travel_cnt;
    logic [NUM_FLOORS-1:0] floor_hot;
    logic [NUM_FLOORS-1:0] eff_calls;
    logic [NUM_FLOORS-1:0] call_mask;
    logic [NUM_FLOORS-1:0] pending_nxt;
    logic                  here, above, below;

    // A call arriving this cycle counts for decisions, so a press coinciding with
    // step_done at that floor still takes the stop. Out-of-range floors match nothing.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        floor_hot = '0;
        above     = 1'b0;
        below     = 1'b0;
        eff_calls = pending | call_req;
        for (int f = 0; f < NUM_FLOORS; f++) begin
            if (int'(car_floor) == f) floor_hot[f] = 1'b1;
            if (eff_calls[f] && f > int'(car_floor)) above = 1'b1;
            if (eff_calls[f] && f < int'(car_floor)) below = 1'b1;
        end
        here = |(eff_calls & floor_hot);
    end

    always_comb begin
        next_state  = state;
        next_dir    = dir_up;
        set_fault   = 1'b0;
        door_reload = 1'b0;
        unique case (state)
            IDLE: begin
                if (!fault) begin
                    if (here) begin
                        next_state = DOOR;
                    end else if (above && (dir_up || !below)) begin
                        next_dir   = 1'b1;
                        next_state = DISPATCH;
                    end else if (below) begin
                        next_dir   = 1'b0;
                        next_state = DISPATCH;
                    end
                end
            end
            DISPATCH: begin
                if (cmd_valid && cmd_ready) next_state = TRAVEL;
            end
            TRAVEL: begin
                if (step_done) begin
                    if (here)                          next_state = DOOR;
                    else if (dir_up ? above : below)   next_state = DISPATCH;
                    else                               next_state = IDLE;
                end else if (travel_cnt == TCNT_W'(TRAVEL_TIMEOUT - 1)) begin
                    set_fault  = 1'b1;
                    next_state = IDLE;
                end
            end
            DOOR: begin
                door_reload = |(call_req & floor_hot);
                if (!door_reload && door_cnt == '0) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Presses at the floor being served only extend the dwell and are never latched.
    always_comb begin
        enter_door  = (next_state == DOOR) && (state != DOOR);
        call_mask   = (state == DOOR) ? (call_req & ~floor_hot) : call_req;
        pending_nxt = (pending | call_mask) & ~(enter_door ? floor_hot : '0);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            pending    <= '0;
            dir_up     <= 1'b1;
            cmd_valid  <= 1'b0;
            cmd_dir    <= 1'b0;
            door_open  <= 1'b0;
            busy       <= 1'b0;
            fault      <= 1'b0;
            door_cnt   <= '0;
            travel_cnt <= '0;
        end else begin
            state     <= next_state;
            pending   <= pending_nxt;
            dir_up    <= next_dir;
            cmd_valid <= (next_state == DISPATCH);
            door_open <= (next_state == DOOR);
            busy      <= (next_state != IDLE);
            fault     <= fault | set_fault;
            if (next_state == DISPATCH) cmd_dir <= next_dir;

            if (enter_door || door_reload)            door_cnt <= DCNT_W'(DOOR_CYCLES - 1);
            else if (state == DOOR && door_cnt != '0) door_cnt <= door_cnt - 1'b1;

            if (state == TRAVEL) travel_cnt <= travel_cnt + 1'b1;
            else                 travel_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Directed bench for elevator_call_scheduler: sweep service, reversal, back-pressure,
// door extension, travel timeout and asynchronous reset.
module tb_elevator_call_scheduler;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] call_req = '0;
    logic [1:0] car_floor = '0;
    logic       cmd_ready = 1'b0;
    logic       step_done = 1'b0;
    logic       cmd_valid, cmd_dir, door_open, dir_up, busy, fault;
    logic [3:0] pending;

    int checks = 0;
    int errors = 0;

    elevator_call_scheduler #(
        .NUM_FLOORS(4), .FLOOR_W(2), .DOOR_CYCLES(8), .TRAVEL_TIMEOUT(64)
    ) dut (
        .clk(clk), .reset_n(reset_n), .call_req(call_req), .car_floor(car_floor),
        .cmd_valid(cmd_valid), .cmd_dir(cmd_dir), .cmd_ready(cmd_ready),
        .step_done(step_done), .door_open(door_open), .pending(pending),
        .dir_up(dir_up), .busy(busy), .fault(fault)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        reset_n   = 1'b0;
        call_req  = '0;
        cmd_ready = 1'b0;
        step_done = 1'b0;
        tick;
        tick;
        #2 reset_n = 1'b1;
        tick;
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!cmd_valid && n < 20) begin
            tick;
            n++;
        end
        checks++;
        if (cmd_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s_wait_valid: cmd_valid got %b want 1 within 20 cycles", name, cmd_valid);
        end
    endtask

    // Accept the pending step, then report arrival at floor fl.
    task automatic do_step(input string name, input logic [1:0] fl);
        wait_valid(name);
        cmd_ready = 1'b1;
        tick;
        cmd_ready = 1'b0;
        car_floor = fl;
        step_done = 1'b1;
        tick;
        step_done = 1'b0;
    endtask

    task automatic door_len(output int n);
        n = 0;
        while (door_open && n < 40) begin
            n++;
            tick;
        end
    endtask

    task automatic test_reset;
        car_floor = 2'd0;
        apply_reset;
        checks++;
        if ({cmd_valid, cmd_dir, door_open, busy, fault} !== 5'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b want 00000", {cmd_valid, cmd_dir, door_open, busy, fault});
        end
        checks++;
        if (pending !== 4'b0000 || dir_up !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: pending=%b dir_up=%b want 0000 1", pending, dir_up);
        end
    endtask

    task automatic test_single_call;
        int n;
        call_req = 4'b0100;
        tick;
        call_req = '0;
        checks++;
        if ({cmd_valid, cmd_dir, busy} !== 3'b111 || pending !== 4'b0100) begin
            errors++;
            $display("FAIL single_dispatch: valid/dir/busy=%b pending=%b want 111 0100", {cmd_valid, cmd_dir, busy}, pending);
        end
        cmd_ready = 1'b1;
        tick;
        cmd_ready = 1'b0;
        checks++;
        if (cmd_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_travel: cmd_valid got %b want 0", cmd_valid);
        end
        car_floor = 2'd1;
        step_done = 1'b1;
        tick;
        step_done = 1'b0;
        checks++;
        if ({cmd_valid, cmd_dir, door_open} !== 3'b110) begin
            errors++;
            $display("FAIL single_pass_floor1: valid/dir/door=%b want 110", {cmd_valid, cmd_dir, door_open});
        end
        do_step("single", 2'd2);
        checks++;
        if (door_open !== 1'b1 || pending !== 4'b0000) begin
            errors++;
            $display("FAIL single_door: door_open=%b pending=%b want 1 0000", door_open, pending);
        end
        door_len(n);
        checks++;
        if (n !== 8 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_dwell: cycles=%0d busy=%b want 8 0", n, busy);
        end
    endtask

    task automatic test_sweep_reversal;
        int n;
        car_floor = 2'd1;
        tick;
        call_req = 4'b1001;
        tick;
        call_req = '0;
        checks++;
        if ({cmd_valid, cmd_dir, dir_up} !== 3'b111 || pending !== 4'b1001) begin
            errors++;
            $display("FAIL sweep_up_first: valid/dir/dir_up=%b pending=%b want 111 1001", {cmd_valid, cmd_dir, dir_up}, pending);
        end
        do_step("sweep_f2", 2'd2);
        checks++;
        if ({cmd_valid, cmd_dir} !== 2'b11) begin
            errors++;
            $display("FAIL sweep_continue_up: valid/dir=%b want 11", {cmd_valid, cmd_dir});
        end
        do_step("sweep_f3", 2'd3);
        checks++;
        if (door_open !== 1'b1 || pending !== 4'b0001) begin
            errors++;
            $display("FAIL sweep_top_door: door_open=%b pending=%b want 1 0001", door_open, pending);
        end
        door_len(n);
        wait_valid("sweep_reverse");
        checks++;
        if (cmd_dir !== 1'b0 || dir_up !== 1'b0) begin
            errors++;
            $display("FAIL sweep_reverse: cmd_dir=%b dir_up=%b want 0 0", cmd_dir, dir_up);
        end
        do_step("sweep_d2", 2'd2);
        do_step("sweep_d1", 2'd1);
        do_step("sweep_d0", 2'd0);
        checks++;
        if (door_open !== 1'b1 || pending !== 4'b0000) begin
            errors++;
            $display("FAIL sweep_bottom_door: door_open=%b pending=%b want 1 0000", door_open, pending);
        end
        door_len(n);
    endtask

    task automatic test_back_pressure;
        int n;
        call_req = 4'b0010;
        tick;
        call_req = '0;
        for (int i = 0; i < 5; i++) begin
            tick;
            checks++;
            if ({cmd_valid, cmd_dir} !== 2'b11) begin
                errors++;
                $display("FAIL bp_hold_%0d: valid/dir=%b want 11", i, {cmd_valid, cmd_dir});
            end
        end
        cmd_ready = 1'b1;
        tick;
        cmd_ready = 1'b0;
        tick;
        checks++;
        if ({cmd_valid, busy} !== 2'b01) begin
            errors++;
            $display("FAIL bp_single_accept: valid/busy=%b want 01", {cmd_valid, busy});
        end
        car_floor = 2'd1;
        step_done = 1'b1;
        tick;
        step_done = 1'b0;
        door_len(n);
        checks++;
        if (n !== 8) begin
            errors++;
            $display("FAIL bp_door: dwell got %0d want 8", n);
        end
    endtask

    task automatic test_door_extend;
        int n;
        call_req = 4'b0100;
        tick;
        call_req = '0;
        do_step("extend", 2'd2);
        repeat (5) tick;
        checks++;
        if (door_open !== 1'b1) begin
            errors++;
            $display("FAIL extend_cycle6: door_open got %b want 1", door_open);
        end
        call_req = 4'b0100;
        tick;
        call_req = '0;
        checks++;
        if (pending !== 4'b0000) begin
            errors++;
            $display("FAIL extend_not_latched: pending got %b want 0000", pending);
        end
        door_len(n);
        checks++;
        if (n !== 8) begin
            errors++;
            $display("FAIL extend_dwell: cycles after press got %0d want 8", n);
        end
    endtask

    task automatic test_timeout;
        logic seen;
        call_req = 4'b0001;
        tick;
        call_req = '0;
        checks++;
        if ({cmd_valid, cmd_dir} !== 2'b10) begin
            errors++;
            $display("FAIL to_dispatch_down: valid/dir=%b want 10", {cmd_valid, cmd_dir});
        end
        cmd_ready = 1'b1;
        tick;
        cmd_ready = 1'b0;
        repeat (63) tick;
        checks++;
        if ({fault, busy} !== 2'b01) begin
            errors++;
            $display("FAIL to_before_limit: fault/busy=%b want 01", {fault, busy});
        end
        tick;
        checks++;
        if ({fault, busy, cmd_valid} !== 3'b100) begin
            errors++;
            $display("FAIL to_fault: fault/busy/valid=%b want 100", {fault, busy, cmd_valid});
        end
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick;
            if (cmd_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0 || fault !== 1'b1 || pending !== 4'b0001) begin
            errors++;
            $display("FAIL to_sticky: seen_valid=%b fault=%b pending=%b want 0 1 0001", seen, fault, pending);
        end
    endtask

    task automatic test_async_reset;
        car_floor = 2'd0;
        apply_reset;
        call_req = 4'b0100;
        tick;
        call_req = '0;
        checks++;
        if (cmd_valid !== 1'b1) begin
            errors++;
            $display("FAIL ar_dispatch: cmd_valid got %b want 1", cmd_valid);
        end
        #3 reset_n = 1'b0;
        #1;
        checks++;
        if ({cmd_valid, busy, fault} !== 3'b000 || pending !== 4'b0000 || dir_up !== 1'b1) begin
            errors++;
            $display("FAIL ar_mid_dispatch: valid/busy/fault=%b pending=%b dir_up=%b want 000 0000 1", {cmd_valid, busy, fault}, pending, dir_up);
        end
        #1 reset_n = 1'b1;
        tick;
        call_req = 4'b0001;
        tick;
        call_req = '0;
        checks++;
        if (door_open !== 1'b1) begin
            errors++;
            $display("FAIL ar_door_open: door_open got %b want 1", door_open);
        end
        #3 reset_n = 1'b0;
        #1;
        checks++;
        if (door_open !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL ar_mid_door: door_open=%b busy=%b want 0 0", door_open, busy);
        end
        #1 reset_n = 1'b1;
        tick;
    endtask

    initial begin
        test_reset;
        test_single_call;
        test_sweep_reversal;
        test_back_pressure;
        test_door_extend;
        test_timeout;
        test_async_reset;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/elevator_call_scheduler.md
Name: elevator_call_scheduler

Overview:
Call-scheduling controller that sits in front of the car motion datapath. It latches floor call buttons into a pending-call register and picks the travel direction using a SCAN (sweep) policy. It issues one-floor step commands to the car over a valid/ready handshake and sequences the door-open dwell at served floors. It also watches travel time and raises a sticky fault if the car stops responding.

Parameters:
NUM_FLOORS, 4, number of floors served (2..16)
FLOOR_W, 2, width of floor index, ceil(log2(NUM_FLOORS))
DOOR_CYCLES, 8, clock cycles door_open stays high per stop (>=1)
TRAVEL_TIMEOUT, 64, max cycles in TRAVEL without step_done before fault

Ports:
clk  in  1  system clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
call_req  in  NUM_FLOORS  call buttons; pulse or level, bit f = call to floor f
car_floor  in  FLOOR_W  current car floor from motion datapath
cmd_valid  out  1  step command valid
cmd_dir  out  1  step direction, 1=up 0=down; stable while cmd_valid
cmd_ready  in  1  motion datapath accepts step
step_done  in  1  one-cycle pulse, step complete; car_floor already updated that cycle
door_open  out  1  door open command
pending  out  NUM_FLOORS  latched outstanding calls
dir_up  out  1  current sweep direction
busy  out  1  high in any state other than IDLE
fault  out  1  sticky travel-timeout flag

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (reset_n). All outputs are registered.
- Reset values: state=IDLE, pending=0, dir_up=1, cmd_valid=0, cmd_dir=0, door_open=0, busy=0, fault=0, counters=0. Reset asserted mid-operation aborts immediately: cmd_valid drops and door_open drops, with no pending handshake carried over.
- Pending latch: each cycle pending <= (pending | call_req) & ~clr. clr is the one-hot of car_floor on the cycle the FSM enters DOOR.
- Call at car_floor while in DOOR: not latched; instead the door counter reloads to DOOR_CYCLES.
- Invalid floor: car_floor >= NUM_FLOORS is treated as having no call and clears nothing.
- above = any pending bit > car_floor; below = any pending bit < car_floor.
- FSM states and transitions:
  - IDLE:
    - if pending[car_floor] -> DOOR.
    - else if above and (dir_up or !below) -> dir_up=1, DISPATCH.
    - else if below -> dir_up=0, DISPATCH.
    - else stay in IDLE.
  - DISPATCH:
    - cmd_valid=1 and cmd_dir=dir_up, held stable until cmd_valid & cmd_ready.
    - On the handshake cycle, cmd_valid drops next cycle and the FSM goes to TRAVEL; the timeout counter clears.
    - No direction change is allowed while cmd_valid is high.
  - TRAVEL:
    - Waits for step_done. On step_done:
      - if pending[car_floor] -> DOOR.
      - else if calls remain in the dir_up direction -> DISPATCH.
      - else -> IDLE, where direction is re-evaluated and reversal is allowed.
    - Timeout counter increments each cycle. At TRAVEL_TIMEOUT: fault=1 (sticky until reset), state -> IDLE, and the FSM then ignores pending calls.
  - DOOR:
    - door_open=1 for exactly DOOR_CYCLES cycles, then -> IDLE.
- Latency: decision cycle -> door_open or cmd_valid high on the next rising edge.
- step_done outside TRAVEL is ignored. cmd_ready outside DISPATCH is ignored.
- Boundary conditions:
  - At top floor with dir_up and no above: reverse via IDLE.
  - At floor 0 with down: same, reverse via IDLE.
  - A call arriving on the same cycle as step_done at that floor is served (stop taken).
- SCAN guarantees no starvation: every pending call is served within one full sweep.

Test Plan:
- Reset, car_floor=0, pulse call_req=4'b0100 -> cmd_valid high next cycle with cmd_dir=1. Ack, step_done with car_floor=1 -> DISPATCH again. step_done with car_floor=2 -> door_open high 8 cycles, pending=0, then IDLE.
- car_floor=1, dir_up=1, pending floors 0 and 3 -> goes up first. Floor 3 door, then reverses: dir_up=0 and floor 0 served.
- Hold cmd_ready=0 for 5 cycles in DISPATCH -> cmd_valid and cmd_dir stay stable. Single accept on cmd_ready=1.
- Door at floor 2, re-press call_req[2] at dwell cycle 6 -> door_open stays high 8 more cycles and pending[2] stays 0.
- Withhold step_done 64 cycles in TRAVEL -> fault=1, FSM to IDLE, no further cmd_valid until reset_n low.
- Assert reset_n low mid-DISPATCH -> cmd_valid, door_open and pending go 0 asynchronously without waiting for clk.
